// File: rtl/up_down_counter_pkg.sv
// Shared constants and parameter checks for the up/down modulus counter.
package up_down_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_SATURATE = 1;

    // True when the out/step widths fit inside the count register.
    function automatic bit widths_ok(input int unsigned width,
                                     input int unsigned out_width,
                                     input int unsigned step_width);
        return (width >= 1) && (out_width >= 1) && (out_width <= width) &&
               (step_width >= 1) && (step_width <= width);
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and wrap/saturation event for one enabled step.
module counter_next_calc
    import up_down_counter_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       STEP_WIDTH = 8,
    parameter logic [WIDTH-1:0]  MAX_VALUE  = {WIDTH{1'b1}},
    parameter int unsigned       SATURATE   = MODE_WRAP
) (
    input  logic [WIDTH-1:0]      count,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  dir,
    output logic [WIDTH-1:0]      next_count,
    output logic                  wrap_event
);

    localparam int unsigned    EW      = WIDTH + 1;
    localparam logic [WIDTH:0] MAX_EXT = EW'(MAX_VALUE);
    localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + EW'(1);
    localparam bit             SAT     = (SATURATE == MODE_SATURATE);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] result;
    logic           overflow;
    logic           underflow;

    // One extra bit keeps MAX_VALUE+1 and count+step representable.
    assign count_ext = EW'(count);
    assign step_ext  = EW'(step);
    assign sum       = count_ext + step_ext;
    assign overflow  = (sum > MAX_EXT);
    assign underflow = (count_ext < step_ext);

    always_comb begin
        result     = count_ext;
        wrap_event = 1'b0;
        if (dir == DIR_UP) begin
            if (!overflow) begin
                result = sum;
            end else if (SAT) begin
                result     = MAX_EXT;
                wrap_event = (count_ext != MAX_EXT);
            end else begin
                result     = sum - MOD_EXT;
                wrap_event = 1'b1;
            end
        end else begin
            if (!underflow) begin
                result = count_ext - step_ext;
            end else if (SAT) begin
                result     = '0;
                wrap_event = (count_ext != '0);
            end else begin
                result     = count_ext + MOD_EXT - step_ext;
                wrap_event = 1'b1;
            end
        end
    end

    assign next_count = WIDTH'(result);

endmodule

// File: rtl/up_down_mod_counter.sv
// Programmable-modulus up/down counter with load, saturate mode and wrap pulse.
module up_down_mod_counter
    import up_down_counter_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       OUT_WIDTH  = 8,
    parameter int unsigned       STEP_WIDTH = 8,
    parameter logic [WIDTH-1:0]  MAX_VALUE  = {WIDTH{1'b1}},
    parameter int unsigned       SATURATE   = MODE_WRAP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  dir,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      count,
    output logic [OUT_WIDTH-1:0]  out,
    output logic                  wrap,
    output logic                  at_max,
    output logic                  at_zero
);

    if (!widths_ok(WIDTH, OUT_WIDTH, STEP_WIDTH)) begin : g_bad_widths
        $error("up_down_mod_counter: illegal OUT_WIDTH/STEP_WIDTH for WIDTH");
    end
    if (SATURATE > MODE_SATURATE) begin : g_bad_mode
        $error("up_down_mod_counter: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] next_count;
    logic             wrap_event;
    logic [WIDTH-1:0] load_clamped;

    counter_next_calc #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH),
        .MAX_VALUE  (MAX_VALUE),
        .SATURATE   (SATURATE)
    ) u_next (
        .count      (count),
        .step       (step),
        .dir        (dir),
        .next_count (next_count),
        .wrap_event (wrap_event)
    );

    assign load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

    // Load beats enable; every non-counting edge clears the wrap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= next_count;
            wrap  <= wrap_event;
        end else begin
            wrap  <= 1'b0;
        end
    end

    assign out     = count[WIDTH-1 -: OUT_WIDTH];
    assign at_max  = (count == MAX_VALUE);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Scoreboard bench: wrap (mod 10), saturate (0..9) and 32-bit natural-wrap counters.
module tb_up_down_mod_counter;

    typedef struct {
        longint c;
        bit     w;
    } exp_t;

    localparam longint MAX_S = 9;
    localparam longint MAX_W = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, dir, ld;
    logic [3:0]  step4;
    logic [7:0]  step8;
    logic [7:0]  lvs;
    logic [31:0] lvw;

    logic [7:0]  cnt_s, cnt_t;
    logic [3:0]  out_s, out_t;
    logic        wrap_s, wrap_t, amax_s, amax_t, azero_s, azero_t;
    logic [31:0] cnt_w;
    logic [7:0]  out_w;
    logic        wrap_w, amax_w, azero_w;

    int n_cmp = 0;
    int n_bad = 0;

    longint ms = 0, mt = 0, mw = 0;
    exp_t qs[$], qt[$], qw[$];

    always #5 clk = ~clk;

    up_down_mod_counter #(.WIDTH(8), .OUT_WIDTH(4), .STEP_WIDTH(4),
                          .MAX_VALUE(8'd9), .SATURATE(0)) dut_s (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .step(step4), .load(ld),
        .load_value(lvs), .count(cnt_s), .out(out_s), .wrap(wrap_s),
        .at_max(amax_s), .at_zero(azero_s));

    up_down_mod_counter #(.WIDTH(8), .OUT_WIDTH(4), .STEP_WIDTH(4),
                          .MAX_VALUE(8'd9), .SATURATE(1)) dut_t (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .step(step4), .load(ld),
        .load_value(lvs), .count(cnt_t), .out(out_t), .wrap(wrap_t),
        .at_max(amax_t), .at_zero(azero_t));

    up_down_mod_counter #(.WIDTH(32), .OUT_WIDTH(8), .STEP_WIDTH(8),
                          .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .step(step8), .load(ld),
        .load_value(lvw), .count(cnt_w), .out(out_w), .wrap(wrap_w),
        .at_max(amax_w), .at_zero(azero_w));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: range 0..mx, modular arithmetic or clamping.
    function automatic void model(input longint cur, input bit l, input longint lv,
                                  input bit e, input bit d, input longint st,
                                  input longint mx, input bit sat,
                                  output longint nxt, output bit w);
        longint raw;
        nxt = cur;
        w   = 1'b0;
        if (l) begin
            nxt = (lv > mx) ? mx : lv;
        end else if (e) begin
            raw = d ? cur + st : cur - st;
            if (sat) begin
                if (raw > mx) begin
                    nxt = mx;
                    w   = (cur != mx);
                end else if (raw < 0) begin
                    nxt = 0;
                    w   = (cur != 0);
                end else begin
                    nxt = raw;
                end
            end else begin
                nxt = ((raw % (mx + 1)) + (mx + 1)) % (mx + 1);
                w   = (raw > mx) || (raw < 0);
            end
        end
    endfunction

    task automatic drive(input bit l, input longint lv_s, input longint lv_w,
                         input bit e, input bit d, input int st);
        longint n;
        bit     w;
        @(negedge clk);
        ld    = l;
        lvs   = 8'(lv_s);
        lvw   = 32'(lv_w);
        en    = e;
        dir   = d;
        step4 = 4'(st);
        step8 = 8'(st);
        model(ms, l, longint'(lvs), e, d, st, MAX_S, 1'b0, n, w);
        ms = n; qs.push_back('{n, w});
        model(mt, l, longint'(lvs), e, d, st, MAX_S, 1'b1, n, w);
        mt = n; qt.push_back('{n, w});
        model(mw, l, longint'(lvw), e, d, st, MAX_W, 1'b0, n, w);
        mw = n; qw.push_back('{n, w});
    endtask

    // Monitor: one expected entry per DUT per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qs.size() > 0) begin
                e = qs.pop_front();
                chk("s_count", 64'(cnt_s), 64'(e.c));
                chk("s_wrap", 64'(wrap_s), 64'(e.w));
                chk("s_out", 64'(out_s), 64'(e.c >> 4));
                chk("s_at_max", 64'(amax_s), 64'(e.c == MAX_S));
                chk("s_at_zero", 64'(azero_s), 64'(e.c == 0));
            end
            if (qt.size() > 0) begin
                e = qt.pop_front();
                chk("t_count", 64'(cnt_t), 64'(e.c));
                chk("t_wrap", 64'(wrap_t), 64'(e.w));
                chk("t_at_max", 64'(amax_t), 64'(e.c == MAX_S));
                chk("t_at_zero", 64'(azero_t), 64'(e.c == 0));
            end
            if (qw.size() > 0) begin
                e = qw.pop_front();
                chk("w_count", 64'(cnt_w), 64'(e.c));
                chk("w_wrap", 64'(wrap_w), 64'(e.w));
                chk("w_out", 64'(out_w), 64'(e.c >> 24));
                chk("w_at_max", 64'(amax_w), 64'(e.c == MAX_W));
                chk("w_at_zero", 64'(azero_w), 64'(e.c == 0));
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0;
        step4 = '0; step8 = '0; lvs = '0; lvw = '0;
        #2;
        chk("rst_count_s", 64'(cnt_s), 64'd0);
        chk("rst_wrap_s", 64'(wrap_s), 64'd0);
        chk("rst_at_zero_s", 64'(azero_s), 64'd1);
        chk("rst_at_max_s", 64'(amax_s), 64'd0);
        chk("rst_out_w", 64'(out_w), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reach 7, then reset asynchronously between edges.
        drive(1'b1, 7, 7, 1'b0, 1'b0, 0);
        @(posedge clk);
        #3;
        ld = 1'b0; en = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_count_s", 64'(cnt_s), 64'd0);
        chk("async_wrap_s", 64'(wrap_s), 64'd0);
        chk("async_at_zero_s", 64'(azero_s), 64'd1);
        chk("async_count_t", 64'(cnt_t), 64'd0);
        chk("async_count_w", 64'(cnt_w), 64'd0);
        ms = 0; mt = 0; mw = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) drive(1'b0, 0, 0, 1'b0, 1'b0, 0);

        // Up by 3 from 0.
        repeat (5) drive(1'b0, 0, 0, 1'b1, 1'b1, 3);
        // Down by 4 from 5.
        drive(1'b1, 5, 5, 1'b0, 1'b0, 0);
        repeat (4) drive(1'b0, 0, 0, 1'b1, 1'b0, 4);
        // Up 4 from 6, then down 5.
        drive(1'b1, 6, 6, 1'b0, 1'b0, 0);
        repeat (3) drive(1'b0, 0, 0, 1'b1, 1'b1, 4);
        repeat (3) drive(1'b0, 0, 0, 1'b1, 1'b0, 5);
        // Load beats enable, clamped to MAX_VALUE.
        drive(1'b1, 200, 200, 1'b1, 1'b1, 1);
        drive(1'b0, 0, 0, 1'b1, 1'b1, 1);
        // 32-bit natural wrap.
        drive(1'b1, 8'hFE, 64'hFFFF_FFFE, 1'b0, 1'b0, 0);
        repeat (3) drive(1'b0, 0, 0, 1'b1, 1'b1, 1);
        // Step zero holds.
        repeat (2) drive(1'b0, 0, 0, 1'b1, 1'b0, 0);

        for (int i = 0; i < 400; i++) begin
            longint lw;
            lw = ($urandom_range(0, 3) == 0) ? (MAX_W - longint'($urandom_range(0, 3)))
                                             : longint'($urandom);
            drive($urandom_range(0, 9) == 0, longint'($urandom_range(0, 255)), lw,
                  $urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 9)));
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("drain", 64'(qs.size() + qt.size() + qw.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
